conv_encoder_frame: RTL and testbench
=====================================

Name: conv_encoder_frame

Overview:
Parametrised, frame-based convolutional encoder with a streaming valid/ready interface on both input bits and output codewords. Constraint length, code rate and generator polynomials are runtime-selectable and latched per frame. Supports zero-tail termination, which appends K-1 flush bits, and truncated termination. It sits ahead of the channel/modulator path in encode mode and replaces the single-bit, free-running encoder path.

Parameters:
K_MAX, 9, maximum constraint length; width of each generator polynomial.
RATE_MAX, 3, maximum number of coded bits per input bit, i.e. code rate 1/RATE_MAX.
FRAME_LEN_W, 16, width of the frame-length field and the internal bit counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
i_start  in  1  one-cycle pulse; latches configuration and starts a frame when idle.
i_frame_len  in  FRAME_LEN_W  number of information bits in the frame; sampled on i_start.
i_k  in  4  active constraint length, legal range 3..K_MAX; sampled on i_start.
i_rate  in  2  active output count, legal range 2..RATE_MAX; sampled on i_start.
i_gen_poly  in  RATE_MAX x K_MAX  generator polynomials; bit k taps register position k; sampled on i_start.
i_term_mode  in  1  0 = zero-tail, 1 = truncated; sampled on i_start.
i_bit  in  1  information bit.
i_bit_valid  in  1  i_bit is valid.
o_bit_ready  out  1  encoder accepts i_bit this cycle.
o_code_data  out  RATE_MAX  codeword; bit i is the output of polynomial i.
o_code_valid  out  1  o_code_data is valid.
i_code_ready  in  1  downstream accepts the codeword.
o_busy  out  1  a frame is in progress.
o_done  out  1  one-cycle pulse after the last codeword of the frame is accepted.
o_err  out  1  one-cycle pulse when i_start carries an illegal configuration.

Behaviour:
- Reset (rst=0, asynchronous) clears everything: shift register, counters, output register, FSM=IDLE. Every output is 0.
- FSM states: IDLE, DATA, TAIL, DRAIN.
- IDLE:
  - On i_start with a legal configuration: latch the configuration, load the bit counter with i_frame_len, clear the shift register, set o_busy=1 on the next cycle, go to DATA.
  - On i_start with an illegal configuration (i_k outside 3..K_MAX, i_rate outside 2..RATE_MAX, or i_frame_len=0): pulse o_err next cycle and stay in IDLE.
- i_start outside IDLE is ignored; there is no error.
- Encoding: mux_state = {shift_reg, in_bit}; in_bit sits at index 0 and older bits at higher indices.
  - Positions >= k_latched are masked to 0.
  - Coded bit i = XOR over k of (mux_state[k] AND gen_poly[i][k]).
  - Bits i >= rate_latched are forced to 0.
  - Shift update: shift_reg <= {shift_reg[K_MAX-3:0], in_bit}.
- Handshake:
  - o_bit_ready = 1 in DATA when the output register is empty, or is being accepted this cycle (o_code_valid & i_code_ready).
  - A bit is accepted on i_bit_valid & o_bit_ready.
  - The codeword is registered and appears with o_code_valid=1 on the following cycle (latency 1).
  - While o_code_valid=1 and i_code_ready=0, o_code_data and o_code_valid hold stable.
- DATA: each accepted bit decrements the bit counter. When the last bit is accepted:
  - zero-tail: go to TAIL with the tail counter = k_latched-1;
  - truncated: go to DRAIN.
- TAIL: internally injects in_bit=0 whenever the output register is free, without using i_bit_valid; o_bit_ready=0. When the tail counter reaches 0, go to DRAIN.
- DRAIN: wait until the final codeword is accepted; then pulse o_done for one cycle, deassert o_busy, return to IDLE.
- Full throughput: one codeword per cycle when i_bit_valid=1 and i_code_ready=1 continuously.
- Codewords per frame = i_frame_len + (k-1) for zero-tail, i_frame_len for truncated.
- Asynchronous reset mid-frame aborts the frame immediately. No o_done is issued, and the partial frame is discarded.

Test Plan:
- K=3, rate=2, gen0=3'b111, gen1=3'b101, zero-tail, len=4, input 1,0,1,1, i_code_ready=1 -> six codewords o_code_data = 3'b011, 001, 000, 010, 010, 011; o_done pulses one cycle after the sixth is accepted.
- Same configuration with i_term_mode=1 -> exactly four codewords 011, 001, 000, 010, then o_done.
- Backpressure: hold i_code_ready=0 for 3 cycles after the first codeword -> o_code_data=3'b011 stays stable, o_bit_ready=0, no bit lost; the full sequence is still correct.
- Illegal configuration: i_start with i_k=2, or i_frame_len=0 -> o_err pulse, o_busy stays 0, no codewords.
- K=9, rate=3, gens 9'o557/9'o663/9'o711, len=16 random bits -> 24 codewords, all matching the reference model bit-exactly.
- Reset asserted after 2 codewords -> all outputs 0 asynchronously; a new i_start then encodes correctly from the all-zero state.

Source files
------------

// File: rtl/conv_encoder_frame.sv
// Frame-based convolutional encoder: runtime-selectable K, rate and polynomials,
// latched per frame, with zero-tail or truncated termination and valid/ready streaming.
module conv_encoder_frame #(
  parameter int K_MAX       = 9,
  parameter int RATE_MAX    = 3,
  parameter int FRAME_LEN_W = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_start,
  input  logic [FRAME_LEN_W-1:0]             i_frame_len,
  input  logic [3:0]                         i_k,
  input  logic [1:0]                         i_rate,
  input  logic [RATE_MAX-1:0][K_MAX-1:0]     i_gen_poly,
  input  logic                               i_term_mode,
  input  logic                               i_bit,
  input  logic                               i_bit_valid,
  output logic                               o_bit_ready,
  output logic [RATE_MAX-1:0]                o_code_data,
  output logic                               o_code_valid,
  input  logic                               i_code_ready,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;

  state_t                           state_q, state_d;
  logic [FRAME_LEN_W-1:0]           cnt_q, cnt_d;
  logic [3:0]                       tail_q, tail_d;
  logic [3:0]                       k_q, k_d;
  logic [1:0]                       rate_q, rate_d;
  logic [RATE_MAX-1:0][K_MAX-1:0]   poly_q, poly_d;
  logic                             term_q, term_d;
  logic [K_MAX-2:0]                 sr_q, sr_d;
  logic [RATE_MAX-1:0]              code_q, code_d;
  logic                             vld_q, vld_d;
  logic                             done_q, done_d;
  logic                             err_q, err_d;

  logic                             cfg_ok;
  logic                             out_free;
  logic                             bit_ready;
  logic                             load;
  logic                             in_bit;
  logic [K_MAX-1:0]                 tap;
  logic [RATE_MAX-1:0]              enc;

  assign cfg_ok = (int'(i_k) >= 3) && (int'(i_k) <= K_MAX) &&
                  (int'(i_rate) >= 2) && (int'(i_rate) <= RATE_MAX) &&
                  (i_frame_len != '0);

  // The output register can take a new codeword when empty or being drained now.
  assign out_free  = ~vld_q | i_code_ready;
  assign bit_ready = (state_q == DATA) & out_free;
  assign load      = (bit_ready & i_bit_valid) | ((state_q == TAIL) & out_free);
  assign in_bit    = (state_q == DATA) & i_bit;

  always_comb begin
    tap = {sr_q, in_bit};
    for (int j = 0; j < K_MAX; j++) begin
      if (j >= int'(k_q)) tap[j] = 1'b0;
    end
    enc = '0;
    for (int i = 0; i < RATE_MAX; i++) begin
      if (i < int'(rate_q)) enc[i] = ^(tap & poly_q[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tail_d  = tail_q;
    k_d     = k_q;
    rate_d  = rate_q;
    poly_d  = poly_q;
    term_d  = term_q;
    sr_d    = sr_q;
    code_d  = code_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (load) begin
      code_d = enc;
      vld_d  = 1'b1;
      sr_d   = {sr_q[K_MAX-3:0], in_bit};
    end else if (i_code_ready) begin
      vld_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (cfg_ok) begin
            k_d     = i_k;
            rate_d  = i_rate;
            poly_d  = i_gen_poly;
            term_d  = i_term_mode;
            cnt_d   = i_frame_len;
            sr_d    = '0;
            state_d = DATA;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      DATA: begin
        if (load) begin
          cnt_d = cnt_q - FRAME_LEN_W'(1);
          if (cnt_q == FRAME_LEN_W'(1)) begin
            if (term_q) begin
              state_d = DRAIN;
            end else begin
              state_d = TAIL;
              tail_d  = k_q - 4'd1;
            end
          end
        end
      end
      TAIL: begin
        if (load) begin
          tail_d = tail_q - 4'd1;
          if (tail_q == 4'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (vld_q & i_code_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tail_q  <= '0;
      k_q     <= '0;
      rate_q  <= '0;
      poly_q  <= '0;
      term_q  <= 1'b0;
      sr_q    <= '0;
      code_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      k_q     <= k_d;
      rate_q  <= rate_d;
      poly_q  <= poly_d;
      term_q  <= term_d;
      sr_q    <= sr_d;
      code_q  <= code_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_bit_ready  = bit_ready;
  assign o_code_data  = code_q;
  assign o_code_valid = vld_q;
  assign o_busy       = (state_q != IDLE);
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_conv_encoder_frame.sv
// Directed bench for conv_encoder_frame: hand-computed K=3 vectors, a K=9 tap model,
// backpressure, illegal configurations and asynchronous reset mid-frame.
module tb_conv_encoder_frame;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start;
  logic [15:0]      i_frame_len;
  logic [3:0]       i_k;
  logic [1:0]       i_rate;
  logic [2:0][8:0]  i_gen_poly;
  logic             i_term_mode;
  logic             i_bit;
  logic             i_bit_valid;
  logic             o_bit_ready;
  logic [2:0]       o_code_data;
  logic             o_code_valid;
  logic             i_code_ready;
  logic             o_busy;
  logic             o_done;
  logic             o_err;

  int errors = 0;
  int checks = 0;

  logic       in_bits [0:31];
  logic [2:0] got     [0:63];
  int         got_n, done_cnt, done_gap, stall_cycles, stall_bad, timed_out;
  logic [2:0] stall_held;

  logic [2:0] exp_k3 [0:5] = '{3'b011, 3'b001, 3'b000, 3'b010, 3'b010, 3'b011};

  always #5 clk = ~clk;

  conv_encoder_frame #(.K_MAX(9), .RATE_MAX(3), .FRAME_LEN_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_frame_len  (i_frame_len),
    .i_k          (i_k),
    .i_rate       (i_rate),
    .i_gen_poly   (i_gen_poly),
    .i_term_mode  (i_term_mode),
    .i_bit        (i_bit),
    .i_bit_valid  (i_bit_valid),
    .o_bit_ready  (o_bit_ready),
    .o_code_data  (o_code_data),
    .o_code_valid (o_code_valid),
    .i_code_ready (i_code_ready),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=%0d required=finish", got_n);
    $fatal(1);
  end

  // Called on a negedge; pulses i_start for one cycle and returns on the next negedge.
  task automatic start_frame(input logic [15:0] len, input logic [3:0] k, input logic [1:0] rate,
                             input logic [2:0][8:0] gp, input logic tm);
    i_frame_len = len;
    i_k         = k;
    i_rate      = rate;
    i_gen_poly  = gp;
    i_term_mode = tm;
    i_start     = 1'b1;
    @(negedge clk);
    i_start     = 1'b0;
  endtask

  // Streams nbits from in_bits, collects accepted codewords and the done pulse.
  // The first codeword is held off for stall_len cycles; stop_at>0 returns after that many codewords.
  task automatic run_frame(input int nbits, input int stall_len, input int stop_at, input int max_cyc);
    int bi;
    int acc_cyc;
    int stall_left;
    bi = 0;
    acc_cyc = -100;
    stall_left = stall_len;
    got_n = 0;
    done_cnt = 0;
    done_gap = -1;
    stall_cycles = 0;
    stall_bad = 0;
    stall_held = '0;
    timed_out = 1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      i_bit_valid  = (bi < nbits);
      i_bit        = (bi < nbits) ? in_bits[bi] : 1'b0;
      i_code_ready = 1'b1;
      #1;
      if (o_code_valid && got_n == 0 && stall_left > 0) begin
        i_code_ready = 1'b0;
        if (stall_left == stall_len) stall_held = o_code_data;
        stall_left--;
        #1;
        stall_cycles++;
        if (o_code_data !== stall_held || o_bit_ready !== 1'b0 || o_code_valid !== 1'b1)
          stall_bad++;
      end else begin
        #1;
      end
      if (o_done) begin
        done_cnt++;
        done_gap = cyc - acc_cyc;
        timed_out = 0;
        break;
      end
      if (i_bit_valid && o_bit_ready) bi++;
      if (o_code_valid && i_code_ready) begin
        if (got_n < 64) got[got_n] = o_code_data;
        got_n++;
        acc_cyc = cyc;
        if (got_n == stop_at) begin
          timed_out = 0;
          break;
        end
      end
      @(negedge clk);
    end
    i_bit_valid  = 1'b0;
    i_code_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    i_start = 1'b0; i_frame_len = '0; i_k = '0; i_rate = '0; i_gen_poly = '0;
    i_term_mode = 1'b0; i_bit = 1'b0; i_bit_valid = 1'b0; i_code_ready = 1'b0;
    #3;
    checks++;
    if ({o_bit_ready, o_code_data, o_code_valid, o_busy, o_done, o_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got=%b required=00000000",
               {o_bit_ready, o_code_data, o_code_valid, o_busy, o_done, o_err});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    i_code_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_code_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b valid=%b required busy=0 valid=0", o_busy, o_code_valid);
    end
  endtask

  task automatic load_k3_bits;
    in_bits[0] = 1'b1; in_bits[1] = 1'b0; in_bits[2] = 1'b1; in_bits[3] = 1'b1;
  endtask

  task automatic test_zero_tail;
    logic [2:0][8:0] gp;
    gp[0] = 9'b000000111; gp[1] = 9'b000000101; gp[2] = 9'b000000110;
    load_k3_bits();
    start_frame(16'd4, 4'd3, 2'd2, gp, 1'b0);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL zt_busy: got=%b required=1", o_busy);
    end
    run_frame(4, 0, 0, 40);
    checks++;
    if (got_n !== 6) begin
      errors++;
      $display("FAIL zt_count: got=%0d required=6", got_n);
    end
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (got[n] !== exp_k3[n]) begin
        errors++;
        $display("FAIL zt_code[%0d]: got=%b required=%b", n, got[n], exp_k3[n]);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_gap !== 1) begin
      errors++;
      $display("FAIL zt_done: pulses=%0d gap=%0d required pulses=1 gap=1", done_cnt, done_gap);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL zt_busy_clear: got=%b required=0", o_busy);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL zt_done_width: got=%b required=0", o_done);
    end
  endtask

  task automatic test_truncated;
    logic [2:0][8:0] gp;
    // Taps above K and polynomial 2 must have no effect at K=3, rate 2.
    gp[0] = 9'b111111111; gp[1] = 9'b000000101; gp[2] = 9'b111111111;
    load_k3_bits();
    start_frame(16'd4, 4'd3, 2'd2, gp, 1'b1);
    run_frame(4, 0, 0, 40);
    checks++;
    if (got_n !== 4) begin
      errors++;
      $display("FAIL tr_count: got=%0d required=4", got_n);
    end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (got[n] !== exp_k3[n]) begin
        errors++;
        $display("FAIL tr_code[%0d]: got=%b required=%b", n, got[n], exp_k3[n]);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_gap !== 1) begin
      errors++;
      $display("FAIL tr_done: pulses=%0d gap=%0d required pulses=1 gap=1", done_cnt, done_gap);
    end
  endtask

  task automatic test_backpressure;
    logic [2:0][8:0] gp;
    gp[0] = 9'b000000111; gp[1] = 9'b000000101; gp[2] = 9'b000000000;
    load_k3_bits();
    start_frame(16'd4, 4'd3, 2'd2, gp, 1'b0);
    run_frame(4, 3, 0, 50);
    checks++;
    if (stall_cycles !== 3 || stall_bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: stall_cycles=%0d unstable=%0d required 3 and 0", stall_cycles, stall_bad);
    end
    checks++;
    if (stall_held !== 3'b011) begin
      errors++;
      $display("FAIL bp_held_data: got=%b required=011", stall_held);
    end
    checks++;
    if (got_n !== 6) begin
      errors++;
      $display("FAIL bp_count: got=%0d required=6", got_n);
    end
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (got[n] !== exp_k3[n]) begin
        errors++;
        $display("FAIL bp_code[%0d]: got=%b required=%b", n, got[n], exp_k3[n]);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL bp_done: pulses=%0d required=1", done_cnt);
    end
  endtask

  task automatic test_illegal;
    logic [2:0][8:0] gp;
    logic [15:0] lens [0:2];
    logic [3:0]  ks   [0:2];
    logic [1:0]  rts  [0:2];
    gp[0] = 9'b111; gp[1] = 9'b101; gp[2] = 9'b0;
    lens[0] = 16'd4; ks[0] = 4'd2;  rts[0] = 2'd2;
    lens[1] = 16'd0; ks[1] = 4'd3;  rts[1] = 2'd2;
    lens[2] = 16'd4; ks[2] = 4'd10; rts[2] = 2'd1;
    for (int c = 0; c < 3; c++) begin
      start_frame(lens[c], ks[c], rts[c], gp, 1'b0);
      checks++;
      if (o_err !== 1'b1 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL ill_err[%0d]: err=%b busy=%b required err=1 busy=0", c, o_err, o_busy);
      end
      i_bit_valid = 1'b1;
      i_bit = 1'b1;
      @(negedge clk);
      checks++;
      if (o_err !== 1'b0 || o_busy !== 1'b0 || o_code_valid !== 1'b0 || o_bit_ready !== 1'b0) begin
        errors++;
        $display("FAIL ill_after[%0d]: err=%b busy=%b valid=%b ready=%b required all 0",
                 c, o_err, o_busy, o_code_valid, o_bit_ready);
      end
      i_bit_valid = 1'b0;
    end
  endtask

  task automatic test_k9;
    logic [2:0][8:0] gp;
    logic [15:0] pat;
    logic [2:0]  e;
    logic        u;
    int          mism;
    gp[0] = 9'o557; gp[1] = 9'o663; gp[2] = 9'o711;
    pat = 16'hB2E6;
    for (int n = 0; n < 16; n++) in_bits[n] = pat[n];
    start_frame(16'd16, 4'd9, 2'd3, gp, 1'b0);
    run_frame(16, 0, 0, 100);
    checks++;
    if (got_n !== 24) begin
      errors++;
      $display("FAIL k9_count: got=%0d required=24", got_n);
    end
    mism = 0;
    for (int n = 0; n < 24; n++) begin
      e = '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 9; j++) begin
          u = (n - j >= 0 && n - j < 16) ? pat[n - j] : 1'b0;
          if (gp[i][j]) e[i] = e[i] ^ u;
        end
      end
      checks++;
      if (n >= got_n || got[n] !== e) begin
        errors++;
        mism++;
        if (mism <= 4) $display("FAIL k9_code[%0d]: got=%b required=%b", n, got[n], e);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL k9_done: pulses=%0d required=1", done_cnt);
    end
  endtask

  task automatic test_reset_midframe;
    logic [2:0][8:0] gp;
    gp[0] = 9'b000000111; gp[1] = 9'b000000101; gp[2] = 9'b000000000;
    load_k3_bits();
    start_frame(16'd4, 4'd3, 2'd2, gp, 1'b0);
    run_frame(4, 0, 2, 40);
    checks++;
    if (got_n !== 2) begin
      errors++;
      $display("FAIL rm_pre: got=%0d codewords required=2", got_n);
    end
    i_bit_valid = 1'b1;
    i_bit = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({o_bit_ready, o_code_data, o_code_valid, o_busy, o_done, o_err} !== 8'h00) begin
      errors++;
      $display("FAIL rm_async_clear: got=%b required=00000000",
               {o_bit_ready, o_code_data, o_code_valid, o_busy, o_done, o_err});
    end
    @(negedge clk);
    i_bit_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rm_no_done: done=%b busy=%b required 0 0", o_done, o_busy);
    end
    start_frame(16'd4, 4'd3, 2'd2, gp, 1'b0);
    run_frame(4, 0, 0, 40);
    checks++;
    if (got_n !== 6 || done_cnt !== 1) begin
      errors++;
      $display("FAIL rm_restart: codewords=%0d done=%0d required 6 and 1", got_n, done_cnt);
    end
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (got[n] !== exp_k3[n]) begin
        errors++;
        $display("FAIL rm_code[%0d]: got=%b required=%b", n, got[n], exp_k3[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_tail();
    test_truncated();
    test_backpressure();
    test_illegal();
    test_k9();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
